// File: rtl/simon_pkg.sv
// Shared constants for the Simon game board front end.
package simon_pkg;

   localparam int DEBOUNCE_CYCLES_HW  = 500000;  // 10 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_SIM = 16;
   localparam int BTN_COUNT           = 4;

endpackage

// File: rtl/button_debounce_bank_if.sv
// Button bank signal bundle: raw pins in, debounced levels and press events out.
interface button_debounce_bank_if
   import simon_pkg::*;
#(
   parameter int NUM_BTN = BTN_COUNT,
   parameter int IDX_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic               press_valid;
   logic [IDX_W-1:0]   press_idx;
   logic               multi_press;

   // master: the debounce bank; slave: board pins plus the game FSM consuming events
   modport master (
      input  btn_raw,
      output btn_level, btn_press, btn_release, press_valid, press_idx, multi_press
   );

   modport slave (
      output btn_raw,
      input  btn_level, btn_press, btn_release, press_valid, press_idx, multi_press
   );

endinterface

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, stability counter, debounced level and edge pulses.
module debounce_chan #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rls,
   output logic press_nxt
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   accept;

   assign s         = sync[SYNC_STAGES-1];
   assign accept    = (s != level) && (cnt == CNT_TC);
   assign press_nxt = accept & s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], raw};
         press <= press_nxt;
         rls   <= accept & ~s;
         // any agreement with the current level discards the partial count
         if (s == level || accept)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (accept)
            level <= s;
      end
   end

endmodule

// File: rtl/button_debounce_bank.sv
// N-channel push-button debouncer with registered press/release pulses and a
// lowest-index-wins press encoder.
module button_debounce_bank
   import simon_pkg::*;
#(
   parameter int NUM_BTN       = BTN_COUNT,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
   input  logic                          clk,
   input  logic                          rst,
   button_debounce_bank_if.master        bus
);

   localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] rls;
   logic [NUM_BTN-1:0] press_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic               multi_nxt;
   logic               valid_q;
   logic [IDX_W-1:0]   idx_q;
   logic               multi_q;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      debounce_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .raw      (bus.btn_raw[i]),
         .level    (level[i]),
         .press    (press[i]),
         .rls      (rls[i]),
         .press_nxt(press_nxt[i])
      );
   end

   // flags follow the next-state press vector so they land on the same edge as btn_press
   always_comb begin
      idx_nxt   = '0;
      multi_nxt = (press_nxt & (press_nxt - 1'b1)) != '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (press_nxt[i])
            idx_nxt = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         multi_q <= 1'b0;
      end else begin
         valid_q <= |press_nxt;
         idx_q   <= idx_nxt;
         multi_q <= multi_nxt;
      end
   end

   assign bus.btn_level   = level;
   assign bus.btn_press   = press;
   assign bus.btn_release = rls;
   assign bus.press_valid = valid_q;
   assign bus.press_idx   = idx_q;
   assign bus.multi_press = multi_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with default parameters (4 buttons, 2 sync, 16 stable).
module tb_button_debounce_bank;
   import simon_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   button_debounce_bank_if #(.NUM_BTN(4)) bus ();

   button_debounce_bank #(
      .NUM_BTN      (4),
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then settle 1 ns past the last one
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // watch n edges for any press or level change away from lvl; returns error count
   task automatic quiet(input int n, input logic [3:0] lvl, output int errs);
      errs = 0;
      for (int k = 0; k < n; k++) begin
         edges(1);
         if (bus.btn_press !== 4'b0 || bus.btn_level !== lvl) errs++;
      end
   endtask

   int errs;

   initial begin
      bus.btn_raw = 4'b0000;
      edges(3);
      chk("rst_level", bus.btn_level, 4'b0);
      chk("rst_press", bus.btn_press, 4'b0);
      chk("rst_rel",   bus.btn_release, 4'b0);
      chk("rst_valid", bus.press_valid, 1'b0);
      chk("rst_idx",   bus.press_idx, 2'd0);
      chk("rst_multi", bus.multi_press, 1'b0);
      rst = 1'b0;
      edges(2);

      // single press on button 2
      bus.btn_raw = 4'b0100;
      edges(17);
      chk("t1_e17_level", bus.btn_level, 4'b0000);
      chk("t1_e17_press", bus.btn_press, 4'b0000);
      edges(1);
      chk("t1_level", bus.btn_level, 4'b0100);
      chk("t1_press", bus.btn_press, 4'b0100);
      chk("t1_valid", bus.press_valid, 1'b1);
      chk("t1_idx",   bus.press_idx, 2'd2);
      chk("t1_multi", bus.multi_press, 1'b0);
      edges(1);
      chk("t1_press_off", bus.btn_press, 4'b0000);
      chk("t1_valid_off", bus.press_valid, 1'b0);
      edges(20);

      // release of the held button
      bus.btn_raw = 4'b0000;
      edges(17);
      chk("t5_e17_rel",   bus.btn_release, 4'b0000);
      chk("t5_e17_level", bus.btn_level, 4'b0100);
      edges(1);
      chk("t5_rel",   bus.btn_release, 4'b0100);
      chk("t5_press", bus.btn_press, 4'b0000);
      chk("t5_level", bus.btn_level, 4'b0000);
      edges(1);
      chk("t5_rel_off", bus.btn_release, 4'b0000);
      edges(5);

      // bouncing button 1: toggles every 3 cycles for 30 cycles, then settles high
      errs = 0;
      for (int seg = 0; seg < 10; seg++) begin
         int e;
         bus.btn_raw = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
         quiet(3, 4'b0000, e);
         errs += e;
      end
      chk("t2_bounce", errs, 0);
      bus.btn_raw = 4'b0010;
      edges(17);
      chk("t2_e17_press", bus.btn_press, 4'b0000);
      edges(1);
      chk("t2_press", bus.btn_press, 4'b0010);
      chk("t2_idx",   bus.press_idx, 2'd1);
      bus.btn_raw = 4'b0000;
      edges(18);
      chk("t2_rel", bus.btn_release, 4'b0010);
      edges(5);

      // button 0 high for 15 cycles: one short of acceptance
      bus.btn_raw = 4'b0001;
      quiet(15, 4'b0000, errs);
      bus.btn_raw = 4'b0000;
      begin
         int e2;
         quiet(25, 4'b0000, e2);
         errs += e2;
      end
      chk("t3_short", errs, 0);

      // button 0 high for exactly 16 cycles
      bus.btn_raw = 4'b0001;
      edges(16);
      bus.btn_raw = 4'b0000;
      edges(1);
      chk("t3_e17_press", bus.btn_press, 4'b0000);
      edges(1);
      chk("t3_press", bus.btn_press, 4'b0001);
      chk("t3_level", bus.btn_level, 4'b0001);
      edges(15);
      chk("t3_e33_rel",   bus.btn_release, 4'b0000);
      chk("t3_e33_level", bus.btn_level, 4'b0001);
      edges(1);
      chk("t3_rel",   bus.btn_release, 4'b0001);
      chk("t3_level0", bus.btn_level, 4'b0000);
      edges(5);

      // simultaneous buttons 0 and 3
      bus.btn_raw = 4'b1001;
      edges(18);
      chk("t4_press", bus.btn_press, 4'b1001);
      chk("t4_idx",   bus.press_idx, 2'd0);
      chk("t4_multi", bus.multi_press, 1'b1);
      chk("t4_valid", bus.press_valid, 1'b1);
      edges(1);
      chk("t4_press_off", bus.btn_press, 4'b0000);
      chk("t4_multi_off", bus.multi_press, 1'b0);
      bus.btn_raw = 4'b0000;
      edges(18);
      chk("t4_rel", bus.btn_release, 4'b1001);
      edges(5);

      // simultaneous buttons 1 and 2: lowest index 1 wins
      bus.btn_raw = 4'b0110;
      edges(18);
      chk("t4b_press", bus.btn_press, 4'b0110);
      chk("t4b_idx",   bus.press_idx, 2'd1);
      chk("t4b_multi", bus.multi_press, 1'b1);
      bus.btn_raw = 4'b0000;
      edges(25);

      // button 3 high, reset once its count reaches 10
      bus.btn_raw = 4'b1000;
      edges(12);
      rst = 1'b1;
      edges(1);
      rst = 1'b0;
      chk("t6_rst_level", bus.btn_level, 4'b0);
      chk("t6_rst_press", bus.btn_press, 4'b0);
      chk("t6_rst_valid", bus.press_valid, 1'b0);
      chk("t6_rst_idx",   bus.press_idx, 2'd0);
      edges(17);
      chk("t6_e17_press", bus.btn_press, 4'b0000);
      edges(1);
      chk("t6_press", bus.btn_press, 4'b1000);
      chk("t6_idx",   bus.press_idx, 2'd3);
      chk("t6_valid", bus.press_valid, 1'b1);
      chk("t6_multi", bus.multi_press, 1'b0);
      edges(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
